fdiv_seq: RTL and testbench
===========================

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 Parameter LAT, default 2: clock cycles the attached fdiv datapath needs from stable operands to valid result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  upstream offers an operand pair.
REQ-005 in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 x  input  32  IEEE-754 single dividend.
REQ-007 y  input  32  IEEE-754 single divisor.
REQ-008 fdiv_x  output  32  registered dividend driven to fdiv.
REQ-009 fdiv_y  output  32  registered divisor driven to fdiv.
REQ-010 fdiv_res  input  32  quotient returned by fdiv.
REQ-011 out_valid  output  1  res/dz hold a completed result.
REQ-012 out_ready  input  1  downstream accepts result this cycle.
REQ-013 res  output  32  registered quotient.
REQ-014 dz  output  1  registered divide-by-zero flag, qualified by out_valid.

Function
REQ-015 The block SHALL implement three states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept SHALL occur on an edge where state is IDLE and in_valid=1; x and y SHALL be latched into operand registers driving fdiv_x/fdiv_y.
REQ-017 Special-case classification SHALL use the incoming x,y at accept, in priority order: y exponent 0 -> res {sx^sy,8'hff,23'b0}, dz=1; x exponent 0 -> res {sx^sy,8'h00,23'b0}, dz=0; x exponent 8'hff -> res {sx^sy,8'hff,23'b0}, dz=0.
REQ-018 A special-case accept SHALL go IDLE -> DONE directly with res/dz loaded on the accept edge; out_valid SHALL rise 1 cycle after accept.
REQ-019 A normal accept SHALL go IDLE -> BUSY, load a 4-bit counter with LAT, and clear dz.
REQ-020 In BUSY the counter SHALL decrement each cycle; on the edge where counter equals 1, fdiv_res SHALL be captured into res and state SHALL go to DONE; out_valid SHALL rise LAT+1 cycles after accept.
REQ-021 fdiv_x/fdiv_y SHALL remain constant from accept until the next accept, including through BUSY and DONE.
REQ-022 In DONE, res and dz SHALL hold constant while out_ready=0; on an edge with out_ready=1 state SHALL go to IDLE.
REQ-023 No operand SHALL be accepted in the cycle a result is consumed; minimum issue interval SHALL be LAT+2 cycles (normal) or 2 cycles (special).
REQ-024 in_valid in BUSY or DONE SHALL be ignored and SHALL not alter any register.
REQ-025 res and dz SHALL not change outside the capture edges of REQ-018/REQ-020.

Reset
REQ-026 With rstn=0 at a rising edge: state IDLE, counter 0, operand registers 0, res 0, dz 0, out_valid 0, in_ready 1 on the following cycle.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; the in-flight result SHALL never be presented.
REQ-028 Reset SHALL take priority over accept and consume on the same edge.

Verification
REQ-029 LAT=2, x=0x40C00000 (6.0), y=0x40000000 (2.0), fdiv modelled with 2-cycle delay -> out_valid at accept+3, res=0x40400000, dz=0.
REQ-030 x=0x3F800000, y=0x00000000 -> out_valid at accept+1, res=0x7F800000, dz=1; y=0x80000000 with x=0x3F800000 -> res=0xFF800000, dz=1.
REQ-031 x=0x80000000, y=0x40400000 -> res=0x80000000, dz=0 at accept+1; fdiv_res not sampled.
REQ-032 Result in DONE, out_ready=0 for 5 cycles with in_valid=1 and changing x -> res, fdiv_x stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 rstn=0 for one edge during BUSY -> out_valid stays 0, res=0, next accept proceeds normally.
REQ-034 Back-to-back stream of 8 random normal pairs, in_valid held 1, out_ready held 1 -> each result equals reference fdiv, issue interval exactly LAT+2 cycles.

Source files
------------

// File: rtl/fdiv_seq.sv
// fdiv_seq: sequencer around a fixed-latency fdiv datapath.
// Latches operands, short-circuits special cases, holds the result until consumed.
module fdiv_seq #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] fdiv_x,
    output logic [31:0] fdiv_y,
    input  logic [31:0] fdiv_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] op_x;
    logic [31:0] op_y;
    logic [31:0] res_q;
    logic        dz_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic        sgn;
    logic        y_zero;
    logic        x_zero;
    logic        x_inf;
    logic        special;
    logic [31:0] spec_res;
    logic        spec_dz;

    assign sgn    = x[31] ^ y[31];
    assign y_zero = (y[30:23] == 8'h00);
    assign x_zero = (x[30:23] == 8'h00);
    assign x_inf  = (x[30:23] == 8'hff);

    // Classify the incoming pair; zero divisor wins over everything else.
    always_comb begin
        special  = 1'b1;
        spec_dz  = 1'b0;
        spec_res = {sgn, 8'hff, 23'h0};
        if (y_zero) begin
            spec_dz = 1'b1;
        end else if (x_zero) begin
            spec_res = {sgn, 8'h00, 23'h0};
        end else if (x_inf) begin
            spec_res = {sgn, 8'hff, 23'h0};
        end else begin
            special = 1'b0;
        end
    end

    // Control FSM: accept, wait out the datapath latency, hold result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            op_x        <= 32'h0;
            op_y        <= 32'h0;
            res_q       <= 32'h0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_x       <= x;
                        op_y       <= y;
                        in_ready_q <= 1'b0;
                        if (special) begin
                            res_q       <= spec_res;
                            dz_q        <= spec_dz;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt   <= 4'(LAT);
                            dz_q  <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        res_q       <= fdiv_res;
                        cnt         <= 4'd0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign fdiv_x    = op_x;
    assign fdiv_y    = op_y;
    assign res       = res_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed bench for fdiv_seq with a transaction-level model
// and a LAT-cycle fdiv datapath stand-in.
module tb_fdiv_seq;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] fdiv_x;
    logic [31:0] fdiv_y;
    logic [31:0] fdiv_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        dz;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    fdiv_seq #(.LAT(LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .fdiv_x    (fdiv_x),
        .fdiv_y    (fdiv_y),
        .fdiv_res  (fdiv_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    function automatic real s2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b);
        if (b[30:23] == 8'h00) return 32'h0;
        return r2s(s2r(a) / s2r(b));
    endfunction

    // fdiv stand-in: result valid LAT cycles after operands settle
    logic [31:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= ref_div(fdiv_x, fdiv_y);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign fdiv_res = pipe[LAT-2];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction model
    int          cyc = 0;
    bit          have = 1'b0;
    int          valid_from = 0;
    logic [31:0] pend_res = 32'h0;
    logic        pend_dz = 1'b0;
    logic [31:0] shown_res = 32'h0;
    logic [31:0] ox = 32'h0;
    logic [31:0] oy = 32'h0;
    int          acc_q[$];

    initial forever begin
        bit ov;
        logic s;
        @(posedge clk);
        ov = have && (cyc >= valid_from);
        if (!rstn) begin
            have = 1'b0;
            shown_res = 32'h0;
            ox = 32'h0;
            oy = 32'h0;
        end else if (ov && out_ready) begin
            have = 1'b0;
        end else if (!have && in_valid) begin
            have = 1'b1;
            ox = x;
            oy = y;
            acc_q.push_back(cyc);
            s = x[31] ^ y[31];
            valid_from = cyc + 1;
            pend_dz = 1'b0;
            if (y[30:23] == 8'h00) begin
                pend_res = {s, 8'hff, 23'h0};
                pend_dz = 1'b1;
            end else if (x[30:23] == 8'h00) begin
                pend_res = {s, 8'h00, 23'h0};
            end else if (x[30:23] == 8'hff) begin
                pend_res = {s, 8'hff, 23'h0};
            end else begin
                pend_res = ref_div(x, y);
                valid_from = cyc + 1 + LAT;
            end
        end
        cyc++;
    end

    // per-cycle compare against the model
    initial forever begin
        bit ov;
        @(negedge clk);
        if (chk_en) begin
            ov = have && (cyc >= valid_from);
            if (ov) shown_res = pend_res;
            check("in_ready", {31'h0, in_ready}, {31'h0, !have});
            check("out_valid", {31'h0, out_valid}, {31'h0, ov});
            check("fdiv_x", fdiv_x, ox);
            check("fdiv_y", fdiv_y, oy);
            check("res", res, shown_res);
            if (ov) check("dz", {31'h0, dz}, {31'h0, pend_dz});
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input bit keep);
        int n0;
        int k;
        x = a;
        y = b;
        in_valid = 1'b1;
        n0 = acc_q.size();
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (acc_q.size() == n0 && k < 50);
        if (acc_q.size() == n0) check("accept_timeout", 32'(k), 32'h0);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        if (!out_valid) check("valid_timeout", 32'(n), 32'h0);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] a;
        logic [31:0] b;
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        int a;
        int b;
        rstn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = 32'h0;
        y = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_res", res, 32'h0);

        send(32'h40C00000, 32'h40000000, 1'b0);
        wait_valid(n);
        check("r029_lat", 32'(n), 32'(LAT + 1));
        check("r029_res", res, 32'h40400000);
        check("r029_dz", {31'h0, dz}, 32'h0);
        consume();

        send(32'h3F800000, 32'h00000000, 1'b0);
        wait_valid(n);
        check("r030a_lat", 32'(n), 32'd1);
        check("r030a_res", res, 32'h7F800000);
        check("r030a_dz", {31'h0, dz}, 32'h1);
        consume();

        send(32'h3F800000, 32'h80000000, 1'b0);
        wait_valid(n);
        check("r030b_res", res, 32'hFF800000);
        check("r030b_dz", {31'h0, dz}, 32'h1);
        consume();

        send(32'h80000000, 32'h40400000, 1'b0);
        wait_valid(n);
        check("r031_lat", 32'(n), 32'd1);
        check("r031_res", res, 32'h80000000);
        check("r031_dz", {31'h0, dz}, 32'h0);
        consume();

        send(32'h41200000, 32'h40A00000, 1'b0);
        wait_valid(n);
        check("r032_res", res, 32'h40000000);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 32'h3F800000 + 32'(i) * 32'h00100000;
            y = 32'h40000000;
            @(negedge clk);
            #1;
        end
        check("r032_hold_res", res, 32'h40000000);
        check("r032_hold_fx", fdiv_x, 32'h41200000);
        check("r032_hold_ir", {31'h0, in_ready}, 32'h0);
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        check("r032_ir_after", {31'h0, in_ready}, 32'h1);

        send(32'h40800000, 32'h40000000, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("r033_ov", {31'h0, out_valid}, 32'h0);
        check("r033_res", res, 32'h0);
        send(32'h41000000, 32'h40000000, 1'b0);
        wait_valid(n);
        check("r033_next", res, 32'h40800000);
        consume();

        out_ready = 1'b1;
        base = acc_q.size();
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(1, 100));
            b = int'($urandom_range(1, 100));
            send(r2s(real'(a * b)), r2s(real'(b)), 1'b1);
        end
        in_valid = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 1; i < 8; i++)
            check("r034_interval", 32'(acc_q[base+i] - acc_q[base+i-1]),
                  32'(LAT + 2));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
